// File: rtl/phoneme_sequencer_if.sv
// Signal bundle joining the phoneme sequencer to its command front end,
// the phoneme address lookup, the sample ROM read port and the audio path.
interface phoneme_sequencer_if;
   logic        ph_valid;
   logic [7:0]  ph_code;
   logic        ph_ready;
   logic        sample_tick;
   logic [7:0]  phoneme_sel;
   logic [23:0] start_address;
   logic [23:0] end_address;
   logic        silent;
   logic        rd_req;
   logic [23:0] rd_addr;
   logic        rd_ack;
   logic [7:0]  rd_data;
   logic [7:0]  sample;
   logic        sample_valid;
   logic        busy;
   logic        ph_done;
   logic        tick_miss;

   modport master (
      input  ph_valid, ph_code, sample_tick, start_address, end_address, silent,
             rd_ack, rd_data,
      output ph_ready, phoneme_sel, rd_req, rd_addr, sample, sample_valid, busy,
             ph_done, tick_miss
   );

   modport slave (
      output ph_valid, ph_code, sample_tick, start_address, end_address, silent,
             rd_ack, rd_data,
      input  ph_ready, phoneme_sel, rd_req, rd_addr, sample, sample_valid, busy,
             ph_done, tick_miss
   );
endinterface

// File: rtl/phoneme_sequencer.sv
// Queues phoneme codes, looks up each code's sample range and plays it one
// byte per sample tick from ROM, or as silence for pause phonemes.
module phoneme_sequencer #(
   parameter int         FIFO_DEPTH  = 8,
   parameter logic [7:0] SILENCE_VAL = 8'h80
) (
   input  logic                clk,
   input  logic                reset,
   phoneme_sequencer_if.master bus
);
   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, SEL, LATCH, WAIT_TICK, FETCH} state_t;
   state_t state, state_nxt;

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push, pop, fifo_empty;

   logic [23:0] cur, last;
   logic        sil;
   logic        start_rd, take_sample, at_last;
   logic [7:0]  sample_nxt;

   assign fifo_empty   = (count == '0);
   assign bus.ph_ready = (count != FULL_CNT);
   assign push         = bus.ph_valid & bus.ph_ready;
   assign at_last      = (cur == last);
   assign bus.busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      start_rd    = 1'b0;
      take_sample = 1'b0;
      sample_nxt  = SILENCE_VAL;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = SEL;
            end
         end
         SEL:   state_nxt = LATCH;
         LATCH: state_nxt = WAIT_TICK;
         WAIT_TICK: begin
            if (bus.sample_tick) begin
               if (sil) begin
                  take_sample = 1'b1;
               end else begin
                  start_rd  = 1'b1;
                  state_nxt = FETCH;
               end
            end
         end
         FETCH: begin
            if (bus.rd_ack) begin
               take_sample = 1'b1;
               sample_nxt  = bus.rd_data;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Advance: the last sample chains straight into the next queued code.
      if (take_sample) begin
         if (at_last) begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = SEL;
            end else begin
               state_nxt = IDLE;
            end
         end else begin
            state_nxt = WAIT_TICK;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.ph_code;
      if (state == LATCH) begin
         cur  <= bus.start_address;
         last <= bus.end_address;
         sil  <= bus.silent;
      end else if (take_sample && !at_last) begin
         cur <= cur + 24'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         bus.phoneme_sel  <= 8'h00;
         bus.rd_req       <= 1'b0;
         bus.rd_addr      <= 24'd0;
         bus.sample       <= SILENCE_VAL;
         bus.sample_valid <= 1'b0;
         bus.ph_done      <= 1'b0;
         bus.tick_miss    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr          <= rd_ptr + 1'b1;
            bus.phoneme_sel <= fifo_mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (start_rd) begin
            bus.rd_req  <= 1'b1;
            bus.rd_addr <= cur;
         end else if (state == FETCH && bus.rd_ack) begin
            bus.rd_req <= 1'b0;
         end
         bus.sample_valid <= take_sample;
         if (take_sample) bus.sample <= sample_nxt;
         bus.ph_done <= take_sample & at_last;
         // A tick during an outstanding read is lost, only flagged.
         if (state == FETCH && bus.sample_tick) bus.tick_miss <= 1'b1;
      end
   end
endmodule

// File: tb/tb_phoneme_sequencer.sv
// Bench for phoneme_sequencer: lookup and ROM models, a sample/address
// scoreboard, a table of single-phoneme vectors and hand-written corner cases.
module tb_phoneme_sequencer;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset;
   phoneme_sequencer_if bus();

   phoneme_sequencer #(.FIFO_DEPTH(DEPTH), .SILENCE_VAL(8'h80)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void lookup(input logic [7:0] code, output logic [23:0] s,
                                  output logic [23:0] e, output logic sl);
      case (code)
         8'h00:   begin s = 24'd0;       e = 24'd72;      sl = 1'b1; end
         8'h05:   begin s = 24'd1408;    e = 24'd3711;    sl = 1'b0; end
         8'h06:   begin s = 24'd4288;    e = 24'd5695;    sl = 1'b0; end
         8'h07:   begin s = 24'd3712;    e = 24'd4287;    sl = 1'b0; end
         8'h09:   begin s = 24'hFFFFFE;  e = 24'h000001;  sl = 1'b0; end
         default: begin s = 24'd0;       e = 24'd0;       sl = 1'b1; end
      endcase
   endfunction

   function automatic logic [7:0] rom_byte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   // Registered lookup: result appears one cycle after phoneme_sel changes.
   logic [7:0]  lk_sel;
   logic [23:0] lk_s, lk_e;
   logic        lk_sl;
   initial begin
      bus.start_address = 24'd0;
      bus.end_address   = 24'd0;
      bus.silent        = 1'b1;
      lk_sel            = 8'h00;
      forever begin
         @(negedge clk);
         lk_sel = bus.phoneme_sel;
         @(posedge clk); #1;
         lookup(lk_sel, lk_s, lk_e, lk_sl);
         bus.start_address = lk_s;
         bus.end_address   = lk_e;
         bus.silent        = lk_sl;
      end
   end

   int          ack_dly = 2;
   bit          rom_en = 1'b1;
   int          man_ack_cnt = 0;
   int          man_served = 0;
   logic [23:0] rom_a;
   initial begin
      bus.rd_ack  = 1'b0;
      bus.rd_data = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (man_ack_cnt != man_served) begin
            man_served++;
            bus.rd_data = 8'h11;
            bus.rd_ack  = 1'b1;
            @(posedge clk); #1;
            bus.rd_ack = 1'b0;
         end else if (rom_en && bus.rd_req) begin
            rom_a = bus.rd_addr;
            repeat (ack_dly - 1) @(posedge clk);
            #1;
            bus.rd_data = rom_byte(rom_a);
            bus.rd_ack  = 1'b1;
            @(posedge clk); #1;
            bus.rd_ack = 1'b0;
         end
      end
   end

   int tick_per = 10;
   bit tick_en = 1'b0;
   int tick_phase = 0;
   initial begin
      bus.sample_tick = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.sample_tick = 1'b0;
         if (tick_en) begin
            tick_phase++;
            if (tick_phase >= tick_per) begin
               tick_phase      = 0;
               bus.sample_tick = 1'b1;
            end
         end
      end
   end

   logic [7:0]  exp_smp_q[$];
   logic [23:0] exp_addr_q[$];
   int          sv_cnt = 0, rd_cnt = 0, done_cnt = 0;
   logic        req_prev = 1'b0;
   logic [23:0] req_addr = 24'd0;
   initial begin
      forever begin
         @(negedge clk);
         if (bus.sample_valid === 1'b1) begin
            sv_cnt++;
            chk("sample_expected", 32'(exp_smp_q.size() != 0), 32'd1);
            if (exp_smp_q.size() != 0) chk("sample", 32'(bus.sample), 32'(exp_smp_q.pop_front()));
         end
         if (bus.rd_req === 1'b1 && !req_prev) begin
            rd_cnt++;
            chk("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) chk("rd_addr", 32'(bus.rd_addr), 32'(exp_addr_q.pop_front()));
            req_addr = bus.rd_addr;
         end else if (bus.rd_req === 1'b1) begin
            chk("rd_addr_stable", 32'(bus.rd_addr), 32'(req_addr));
         end
         if (bus.ph_done === 1'b1) done_cnt++;
         req_prev = (bus.rd_req === 1'b1);
      end
   end

   task automatic expect_phoneme(input logic [7:0] code);
      logic [23:0] s, e, a, d;
      logic        sl;
      int          n;
      lookup(code, s, e, sl);
      d = e - s;
      n = int'(d) + 1;
      a = s;
      for (int i = 0; i < n; i++) begin
         if (!sl) exp_addr_q.push_back(a);
         exp_smp_q.push_back(sl ? 8'h80 : rom_byte(a));
         a = a + 24'd1;
      end
   endtask

   task automatic push_code(input logic [7:0] code);
      chk("ph_ready_on_push", 32'(bus.ph_ready), 32'd1);
      bus.ph_code  = code;
      bus.ph_valid = 1'b1;
      expect_phoneme(code);
      @(posedge clk); #1;
      bus.ph_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (done_cnt < target && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk(name, 32'(done_cnt), 32'(target));
   endtask

   typedef struct {
      logic [7:0] code;
      int         tper;
      int         adly;
      int         exp_n;
      int         exp_rd;
   } vec_t;
   vec_t vecs[4];

   logic [7:0] fill_codes[DEPTH];

   initial begin
      int d0, sv0, rd0, k, idle_cyc;
      vecs[0] = '{8'h07, 10, 2, 576, 576};
      vecs[1] = '{8'h00, 10, 2, 73, 0};
      vecs[2] = '{8'h33, 6, 2, 1, 0};
      vecs[3] = '{8'h09, 6, 3, 4, 4};
      fill_codes = '{8'h33, 8'h09, 8'h33, 8'h33, 8'h09, 8'h33, 8'h33, 8'h09};

      bus.ph_valid = 1'b0;
      bus.ph_code  = 8'h00;
      reset        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ph_ready", 32'(bus.ph_ready), 32'd1);
      chk("rst_phoneme_sel", 32'(bus.phoneme_sel), 32'h00);
      chk("rst_rd_req", 32'(bus.rd_req), 32'd0);
      chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      chk("rst_sample", 32'(bus.sample), 32'h80);
      chk("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ph_done", 32'(bus.ph_done), 32'd0);
      chk("rst_tick_miss", 32'(bus.tick_miss), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single-phoneme vectors, including the default entry and an address wrap.
      tick_en = 1'b1;
      for (int v = 0; v < 4; v++) begin
         tick_per = vecs[v].tper;
         ack_dly  = vecs[v].adly;
         d0 = done_cnt; sv0 = sv_cnt; rd0 = rd_cnt;
         push_code(vecs[v].code);
         chk("busy_before_sel", 32'(bus.busy), 32'd0);
         @(posedge clk); #1;
         chk("sel_latency", 32'(bus.phoneme_sel), 32'(vecs[v].code));
         chk("busy_with_sel", 32'(bus.busy), 32'd1);
         wait_done(d0 + 1, vecs[v].exp_n * (vecs[v].tper + vecs[v].adly + 6) + 100, "vec_ph_done");
         repeat (3) @(posedge clk);
         #1;
         chk("vec_done_once", 32'(done_cnt - d0), 32'd1);
         chk("vec_samples", 32'(sv_cnt - sv0), 32'(vecs[v].exp_n));
         chk("vec_reads", 32'(rd_cnt - rd0), 32'(vecs[v].exp_rd));
         chk("vec_queue_drained", 32'(exp_smp_q.size()), 32'd0);
         chk("vec_idle", 32'(bus.busy), 32'd0);
      end

      // Back-to-back phonemes chain without an IDLE cycle.
      tick_per = 5; ack_dly = 2;
      d0 = done_cnt; sv0 = sv_cnt; rd0 = rd_cnt;
      push_code(8'h05);
      push_code(8'h00);
      push_code(8'h06);
      k = 0; idle_cyc = 0;
      while (done_cnt < d0 + 3 && k < 40000) begin
         @(posedge clk); #1;
         k++;
         if (done_cnt < d0 + 2 && bus.busy !== 1'b1) idle_cyc++;
      end
      chk("b2b_ph_done", 32'(done_cnt - d0), 32'd3);
      chk("b2b_no_idle", 32'(idle_cyc), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_samples", 32'(sv_cnt - sv0), 32'd3785);
      chk("b2b_reads", 32'(rd_cnt - rd0), 32'd3712);
      chk("b2b_idle", 32'(bus.busy), 32'd0);
      chk("no_tick_miss_yet", 32'(bus.tick_miss), 32'd0);

      // FIFO fill with the sequencer stalled waiting for a tick.
      tick_en = 1'b0;
      d0 = done_cnt;
      push_code(8'h09);
      repeat (4) @(posedge clk);
      #1;
      bus.ph_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.ph_code = fill_codes[i];
         chk("ready_while_filling", 32'(bus.ph_ready), 32'd1);
         expect_phoneme(fill_codes[i]);
         @(posedge clk); #1;
      end
      chk("full_after_depth", 32'(bus.ph_ready), 32'd0);
      bus.ph_code = 8'h00;
      repeat (5) begin
         @(posedge clk); #1;
         chk("ready_held_low", 32'(bus.ph_ready), 32'd0);
      end
      bus.ph_valid = 1'b0;
      tick_per = 6; ack_dly = 2; tick_en = 1'b1;
      wait_done(d0 + DEPTH + 1, 2000, "fill_ph_done");
      repeat (200) @(posedge clk);
      #1;
      chk("fill_no_extra", 32'(done_cnt - d0), 32'(DEPTH + 1));
      chk("fill_queue_drained", 32'(exp_smp_q.size()), 32'd0);
      chk("fill_idle", 32'(bus.busy), 32'd0);

      // Slow ROM: ticks land during FETCH.
      tick_per = 10; ack_dly = 15;
      d0 = done_cnt;
      push_code(8'h09);
      wait_done(d0 + 1, 400, "miss_ph_done");
      chk("tick_miss_set", 32'(bus.tick_miss), 32'd1);
      ack_dly = 2;
      push_code(8'h33);
      wait_done(d0 + 2, 200, "miss_next_done");
      chk("tick_miss_sticky", 32'(bus.tick_miss), 32'd1);
      chk("miss_queue_drained", 32'(exp_addr_q.size()), 32'd0);

      // Reset during an outstanding read; a late ack must be ignored.
      rom_en = 1'b0; tick_per = 5;
      repeat (3) @(posedge clk);
      #1;
      push_code(8'h07);
      push_code(8'h05);
      k = 0;
      while (bus.rd_req !== 1'b1 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reached_fetch", 32'(bus.rd_req), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_mid_rd_req", 32'(bus.rd_req), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      chk("rst_mid_sample", 32'(bus.sample), 32'h80);
      chk("rst_mid_ready", 32'(bus.ph_ready), 32'd1);
      chk("rst_mid_tick_miss", 32'(bus.tick_miss), 32'd0);
      chk("rst_mid_sel", 32'(bus.phoneme_sel), 32'h00);
      exp_smp_q.delete();
      exp_addr_q.delete();
      sv0 = sv_cnt;
      man_ack_cnt++;
      repeat (30) @(posedge clk);
      #1;
      chk("late_ack_ignored", 32'(sv_cnt - sv0), 32'd0);
      chk("fifo_empty_after_rst", 32'(bus.busy), 32'd0);

      rom_en = 1'b1;
      d0 = done_cnt;
      push_code(8'h09);
      wait_done(d0 + 1, 200, "recover_ph_done");
      chk("recover_queue_drained", 32'(exp_smp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
